// File: rtl/p2s_tx.sv
// p2s_tx: four-lane parallel-to-serial transmitter, one bit per lane per CLK.
// Optional build macro P2S_IDLE_PATTERN_EN: lanes shift IDLE_WORD while idle.
module p2s_tx #(
    parameter logic [7:0] IDLE_WORD = 8'hBC
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       ENB,
    input  logic [7:0] D0,
    input  logic [7:0] D1,
    input  logic [7:0] D2,
    input  logic [7:0] D3,
    input  logic       VALID,
    output logic       READY,
    input  logic       DIR,
    output logic [3:0] S_OUT,
    output logic       FRAME,
    output logic       BUSY
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [3:0][7:0] sr_q, sr_d;
    logic            dir_q, dir_d;
    logic [3:0]      s_out_q, s_out_d;
    logic            frame_q, frame_d;
    logic            busy_q, busy_d;

    logic [3:0][7:0] din;
    logic            last_bit;
    logic            hs;

    assign din      = {D3, D2, D1, D0};
    assign last_bit = (cnt_q == 3'd7);

`ifdef P2S_IDLE_PATTERN_EN
    // Data may only start on a character boundary of the idle stream.
    assign READY = ENB & last_bit;
`else
    assign READY = ENB & ((state_q == IDLE) | last_bit);
`endif

    assign hs = VALID & READY;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        dir_d   = dir_q;
        s_out_d = s_out_q;
        frame_d = frame_q;
        busy_d  = busy_q;
        if (ENB) begin
            frame_d = 1'b0;
            if (hs) begin
                state_d = SHIFT;
                cnt_d   = 3'd0;
                dir_d   = DIR;
                frame_d = 1'b1;
                busy_d  = 1'b1;
                for (int i = 0; i < 4; i++) begin
                    s_out_d[i] = DIR ? din[i][0] : din[i][7];
                    sr_d[i]    = DIR ? (din[i] >> 1) : (din[i] << 1);
                end
            end else if (!last_bit) begin
                // The next bit to send always sits at the outgoing end.
                cnt_d = cnt_q + 3'd1;
                for (int i = 0; i < 4; i++) begin
                    s_out_d[i] = dir_q ? sr_q[i][0] : sr_q[i][7];
                    sr_d[i]    = dir_q ? (sr_q[i] >> 1) : (sr_q[i] << 1);
                end
            end else begin
                state_d = IDLE;
                busy_d  = 1'b0;
`ifdef P2S_IDLE_PATTERN_EN
                cnt_d   = 3'd0;
                dir_d   = DIR;
                for (int i = 0; i < 4; i++) begin
                    s_out_d[i] = DIR ? IDLE_WORD[0] : IDLE_WORD[7];
                    sr_d[i]    = DIR ? (IDLE_WORD >> 1) : (IDLE_WORD << 1);
                end
`else
                cnt_d   = 3'd7;
                s_out_d = 4'b0000;
                sr_d    = '0;
`endif
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 3'd7;
            sr_q    <= '0;
            dir_q   <= 1'b0;
            s_out_q <= 4'b0000;
            frame_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            dir_q   <= dir_d;
            s_out_q <= s_out_d;
            frame_q <= frame_d;
            busy_q  <= busy_d;
        end
    end

    assign S_OUT = s_out_q;
    assign FRAME = frame_q;
    assign BUSY  = busy_q;

endmodule
